// File: rtl/velocity_cell_pingpong_mem_pkg.sv
// Shared constants and types for the ping-pong velocity store.
// Word packing is {vz, vy, vx}; bank address 0 holds the particle count.
package velocity_cell_pingpong_mem_pkg;

  localparam int COMP_W   = 32;
  localparam int VEL_W    = 3 * COMP_W;
  localparam int CNT_ADDR = 0;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } swap_state_t;

  typedef enum logic [1:0] {
    RK_RAM,
    RK_CNT,
    RK_ZERO
  } rd_kind_t;

endpackage

// File: rtl/velocity_cell_pingpong_mem_if.sv
// Read / write / swap bus of the ping-pong velocity store.
// master drives requests; slave (the store) returns data and status.
interface velocity_cell_pingpong_mem_if #(
  parameter int DW = 96,
  parameter int AW = 8
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          active_bank;
  logic [AW-1:0] active_cnt;
  logic          addr_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    input  rd_data, rd_valid, swap_ack, active_bank, active_cnt, addr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    output rd_data, rd_valid, swap_ack, active_bank, active_cnt, addr_err
  );
endinterface

// File: rtl/velocity_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clock, we/waddr/wdata, re/raddr, rdata (1-cycle latency, holds).
module velocity_bank_ram #(
  parameter int DW    = 96,
  parameter int DEPTH = 220,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/velocity_cell_pingpong_mem.sv
// Double-buffered velocity store: reads hit the active bank, writes the shadow.
// Ports: clock, rst_n (sync, active-low), bus (slave side of the store bus).
module velocity_cell_pingpong_mem
  import velocity_cell_pingpong_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = VEL_W,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter bit CLEAR_ON_SWAP = 1'b1
) (
  input logic clock,
  input logic rst_n,
  velocity_cell_pingpong_mem_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] PN =
    PARTICLE_NUM[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] CA =
    CNT_ADDR[ADDR_WIDTH-1:0];

  swap_state_t state, state_nx;
  logic do_swap;
  logic act;
  logic err;
  logic [ADDR_WIDTH-1:0] cnt [2];

  logic rd_ok, rd_cnt, wr_ok, wr_cnt;
  logic rd_ram, wr_ram;
  logic [1:0] we, re;
  logic [DATA_WIDTH-1:0] q0, q1;

  logic rd_valid_q;
  logic rd_bank_q;
  rd_kind_t rd_kind_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q;

  assign rd_ok  = {1'b0, bus.rd_addr} < PN;
  assign wr_ok  = {1'b0, bus.wr_addr} < PN;
  assign rd_cnt = bus.rd_addr == CA;
  assign wr_cnt = bus.wr_addr == CA;
  assign rd_ram = rst_n & bus.rd_en & rd_ok & ~rd_cnt;
  assign wr_ram = rst_n & bus.wr_en & wr_ok & ~wr_cnt;

  // Writes go to the bank that is not active; reads to the active one.
  assign we = {wr_ram & ~act, wr_ram & act};
  assign re = {rd_ram & act, rd_ram & ~act};

  velocity_bank_ram #(
    .DW(DATA_WIDTH), .DEPTH(PARTICLE_NUM), .AW(ADDR_WIDTH)
  ) u_bank0 (
    .clock(clock),
    .we(we[0]), .waddr(bus.wr_addr), .wdata(bus.wr_data),
    .re(re[0]), .raddr(bus.rd_addr), .rdata(q0)
  );

  velocity_bank_ram #(
    .DW(DATA_WIDTH), .DEPTH(PARTICLE_NUM), .AW(ADDR_WIDTH)
  ) u_bank1 (
    .clock(clock),
    .we(we[1]), .waddr(bus.wr_addr), .wdata(bus.wr_data),
    .re(re[1]), .raddr(bus.rd_addr), .rdata(q1)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_swap  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.swap_req) begin
          do_swap  = 1'b1;
          state_nx = S_ACK;
        end
      end
      S_ACK: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      act        <= 1'b0;
      err        <= 1'b0;
      cnt[0]     <= '0;
      cnt[1]     <= '0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_kind_q  <= RK_ZERO;
      rd_cnt_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_bank_q <= act;
        rd_cnt_q  <= cnt[act];
        unique case (1'b1)
          !rd_ok:  rd_kind_q <= RK_ZERO;
          rd_cnt:  rd_kind_q <= RK_CNT;
          default: rd_kind_q <= RK_RAM;
        endcase
      end
      if ((bus.rd_en && !rd_ok) || (bus.wr_en && !wr_ok))
        err <= 1'b1;
      // The cleared count (old active) and a written count (old shadow)
      // are different registers, so a same-cycle count write survives.
      if (do_swap) begin
        act <= ~act;
        if (CLEAR_ON_SWAP) cnt[act] <= '0;
      end
      if (bus.wr_en && wr_ok && wr_cnt)
        cnt[~act] <= bus.wr_data[ADDR_WIDTH-1:0];
    end
  end

  // Output mux is driven from registers only, so rd_data holds while idle.
  always_comb begin
    bus.rd_data = '0;
    unique case (rd_kind_q)
      RK_RAM:  bus.rd_data = rd_bank_q ? q1 : q0;
      RK_CNT:  bus.rd_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, rd_cnt_q};
      default: bus.rd_data = '0;
    endcase
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.swap_ack    = state == S_ACK;
  assign bus.active_bank = act;
  assign bus.active_cnt  = cnt[act];
  assign bus.addr_err    = err;

endmodule

// File: tb/tb_velocity_cell_pingpong_mem.sv
// Self-checking bench for velocity_cell_pingpong_mem.
// Two instances (count clear on / off) share one stimulus stream.
module tb_velocity_cell_pingpong_mem;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  velocity_cell_pingpong_mem_if #(.DW(DW), .AW(AW)) ifc ();
  velocity_cell_pingpong_mem_if #(.DW(DW), .AW(AW)) ifk ();

  assign ifk.rd_en    = ifc.rd_en;
  assign ifk.rd_addr  = ifc.rd_addr;
  assign ifk.wr_en    = ifc.wr_en;
  assign ifk.wr_addr  = ifc.wr_addr;
  assign ifk.wr_data  = ifc.wr_data;
  assign ifk.swap_req = ifc.swap_req;

  velocity_cell_pingpong_mem #(.CLEAR_ON_SWAP(1'b1)) dut_c (
    .clock(clock), .rst_n(rst_n), .bus(ifc.slave)
  );
  velocity_cell_pingpong_mem #(.CLEAR_ON_SWAP(1'b0)) dut_k (
    .clock(clock), .rst_n(rst_n), .bus(ifk.slave)
  );

  // Behavioural reference: two arrays, two counts per instance.
  logic [DW-1:0] mem [2][PN];
  logic [AW-1:0] cc [2];
  logic [AW-1:0] ck [2];
  int act;
  bit err, ack, vld;
  logic [DW-1:0] dc, dk;
  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.rd_en = 0;
    ifc.wr_en = 0;
    ifc.swap_req = 0;
  endtask

  task automatic rd(int a);
    ifc.rd_en = 1;
    ifc.rd_addr = AW'(a);
  endtask

  task automatic wr(int a, logic [DW-1:0] d);
    ifc.wr_en = 1;
    ifc.wr_addr = AW'(a);
    ifc.wr_data = d;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    int a;
    if (!rst_n) begin
      act = 0; err = 0; ack = 0; vld = 0;
      dc = '0; dk = '0;
      cc[0] = '0; cc[1] = '0; ck[0] = '0; ck[1] = '0;
    end else begin
      vld = ifc.rd_en;
      if (ifc.rd_en) begin
        a = int'(ifc.rd_addr);
        if (a >= PN) begin
          dc = '0; dk = '0; err = 1;
        end else if (a == 0) begin
          dc = DW'(cc[act]); dk = DW'(ck[act]);
        end else begin
          dc = mem[act][a]; dk = dc;
        end
      end
      if (ifc.wr_en) begin
        a = int'(ifc.wr_addr);
        if (a >= PN) err = 1;
        else if (a == 0) begin
          cc[1-act] = ifc.wr_data[AW-1:0];
          ck[1-act] = ifc.wr_data[AW-1:0];
        end else mem[1-act][a] = ifc.wr_data;
      end
      if (ifc.swap_req && !ack) begin
        cc[act] = '0;
        act = 1 - act;
        ack = 1;
      end else ack = 0;
    end
    @(posedge clock);
    #1;
    chk("rd_valid", DW'(ifc.rd_valid), DW'(vld));
    chk("rd_data", ifc.rd_data, dc);
    chk("rd_data_k", ifk.rd_data, dk);
    chk("swap_ack", DW'(ifc.swap_ack), DW'(ack));
    chk("active_bank", DW'(ifc.active_bank), DW'(act));
    chk("active_cnt", DW'(ifc.active_cnt), DW'(cc[act]));
    chk("active_cnt_k", DW'(ifk.active_cnt), DW'(ck[act]));
    chk("addr_err", DW'(ifc.addr_err), DW'(err));
    chk("addr_err_k", DW'(ifk.addr_err), DW'(err));
  endtask

  task automatic rand_cycles(int n, bit oor);
    for (int i = 0; i < n; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        if (oor && $urandom_range(0, 15) == 0)
          rd($urandom_range(PN, 255));
        else rd($urandom_range(0, PN-1));
      end
      if ($urandom_range(0, 1) != 0) begin
        if (oor && $urandom_range(0, 15) == 0)
          wr($urandom_range(PN, 255), rnd());
        else wr($urandom_range(0, PN-1), rnd());
      end
      ifc.swap_req = $urandom_range(0, 7) == 0;
      tick();
    end
  endtask

  logic [DW-1:0] v, old;
  logic [DW-1:0] k3;

  initial begin
    ifc.rd_addr = '0;
    ifc.wr_addr = '0;
    ifc.wr_data = '0;
    idle();

    // Reset with a swap and a count write present: both discarded.
    rst_n = 0;
    ifc.swap_req = 1;
    wr(0, 96'd7);
    tick();
    tick();
    chk("rst_bank", DW'(ifc.active_bank), '0);
    chk("rst_cnt", DW'(ifc.active_cnt), '0);
    chk("rst_ack", DW'(ifc.swap_ack), '0);
    rst_n = 1;
    idle();
    tick();

    // Fill both banks so every read has a known reference value.
    for (int b = 0; b < 2; b++) begin
      for (int a = 1; a < PN; a++) begin
        idle(); wr(a, rnd()); tick();
      end
      idle(); ifc.swap_req = 1; tick();
      idle(); tick();
    end

    // 1: count 5 and {k,k,k} words, then swap and read back.
    idle(); wr(0, 96'd5); tick();
    for (int k = 1; k <= 5; k++) begin
      idle(); wr(k, {32'(k), 32'(k), 32'(k)}); tick();
    end
    idle(); ifc.swap_req = 1; tick();
    chk("t1_ack", DW'(ifc.swap_ack), 96'd1);
    chk("t1_bank", DW'(ifc.active_bank), 96'd1);
    chk("t1_cnt", DW'(ifc.active_cnt), 96'd5);
    idle(); rd(3); tick();
    k3 = {32'd3, 32'd3, 32'd3};
    chk("t1_rd3", ifc.rd_data, k3);
    chk("t1_ack_gone", DW'(ifc.swap_ack), '0);

    // 2: back-to-back reads while the shadow word 2 is overwritten.
    idle(); rd(2); wr(2, {24{4'hA}}); tick();
    chk("t2_rd2", ifc.rd_data, {32'd2, 32'd2, 32'd2});
    idle(); rd(4); tick();
    chk("t2_rd4", ifc.rd_data, {32'd4, 32'd4, 32'd4});
    chk("t2_valid", DW'(ifc.rd_valid), 96'd1);
    idle(); tick();
    chk("t2_hold", ifc.rd_data, {32'd4, 32'd4, 32'd4});

    // 3: write, swap and read of address 7 in the same cycle.
    v = rnd();
    old = mem[1][7];
    idle(); wr(7, v); rd(7); ifc.swap_req = 1; tick();
    chk("t3_old", ifc.rd_data, old);
    idle(); rd(7); tick();
    chk("t3_new", ifc.rd_data, v);

    // 4: count clear on swap versus keep.
    idle(); wr(0, 96'd5); ifc.swap_req = 1; tick();
    idle(); tick();
    idle(); wr(0, 96'd9); ifc.swap_req = 1; tick();
    chk("t4_cnt9", DW'(ifc.active_cnt), 96'd9);
    chk("t4_cnt9_k", DW'(ifk.active_cnt), 96'd9);
    idle(); tick();
    idle(); ifc.swap_req = 1; tick();
    tick();
    chk("t4_ack_ign", DW'(ifc.swap_ack), '0);
    chk("t4_cnt_c", DW'(ifc.active_cnt), '0);
    chk("t4_cnt_k", DW'(ifk.active_cnt), 96'd5);
    idle(); ifc.swap_req = 1; tick();
    chk("t4_sh_c", DW'(ifc.active_cnt), '0);
    chk("t4_sh_k", DW'(ifk.active_cnt), 96'd9);
    idle(); tick();

    rand_cycles(300, 1'b0);
    idle(); tick();
    chk("pre_err", DW'(ifc.addr_err), '0);

    // 5: out-of-range read and write.
    idle(); rd(PN); tick();
    chk("t5_rd0", ifc.rd_data, '0);
    chk("t5_err", DW'(ifc.addr_err), 96'd1);
    idle(); wr(255, '1); tick();
    idle(); wr(PN, '1); tick();
    idle(); tick();
    chk("t5_sticky", DW'(ifc.addr_err), 96'd1);
    idle(); ifc.swap_req = 1; tick();
    for (int a = 0; a < PN; a++) begin
      idle(); rd(a); tick();
    end

    // 6: reset during the acknowledge cycle with a read in flight.
    idle(); ifc.swap_req = 1; tick();
    chk("t6_ack", DW'(ifc.swap_ack), 96'd1);
    rst_n = 0;
    idle(); rd(3); tick();
    chk("t6_ack0", DW'(ifc.swap_ack), '0);
    chk("t6_bank0", DW'(ifc.active_bank), '0);
    chk("t6_vld0", DW'(ifc.rd_valid), '0);
    rst_n = 1;
    idle(); tick();
    chk("t6_vld_after", DW'(ifc.rd_valid), '0);
    idle(); rd(0); tick();
    chk("t6_cnt0", ifc.rd_data, '0);

    rand_cycles(200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
